// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel LED PWM with snap-on request and linear fade-out.
// Define LED_FADE_GAMMA_EN to square the level into the duty for a smoother perceived fade.
module led_fade_pwm #(
   parameter int CHANNELS   = 4,
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 16,
   parameter int DECAY_STEP = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] led_req,
   output logic [CHANNELS-1:0] led_o,
   output logic                active
);
   localparam logic [PWM_BITS-1:0] MAX  = '1;
   localparam logic [PWM_BITS:0]   STEP = DECAY_STEP[PWM_BITS:0];

   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [DECAY_DIV-1:0] div;
   logic                 started;
   logic                 decay_tick;
   logic                 any_on;
   logic [PWM_BITS-1:0]  level    [CHANNELS];
   logic [PWM_BITS-1:0]  level_nx [CHANNELS];
   logic [PWM_BITS:0]    diff     [CHANNELS];
   logic [PWM_BITS-1:0]  duty     [CHANNELS];
   logic [PWM_BITS-1:0]  duty_sh  [CHANNELS];
`ifdef LED_FADE_GAMMA_EN
   logic [2*PWM_BITS-1:0] sq      [CHANNELS];
`endif

   // the divider also reads zero on the first cycle out of reset, which must not decay
   assign decay_tick = started && div == '0;

   always_comb begin
      any_on = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         diff[i]     = {1'b0, level[i]} - STEP;
         level_nx[i] = led_req[i] ? MAX :
                       decay_tick ? (diff[i][PWM_BITS] ? '0 : diff[i][PWM_BITS-1:0]) :
                       level[i];
`ifdef LED_FADE_GAMMA_EN
         sq[i]       = (2*PWM_BITS)'(level[i]) * (2*PWM_BITS)'(level[i]);
         duty[i]     = level[i] == MAX ? MAX : sq[i][2*PWM_BITS-1:PWM_BITS];
`else
         duty[i]     = level[i];
`endif
         any_on      = any_on | (level[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         div     <= '0;
         started <= 1'b0;
         led_o   <= '0;
         active  <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            level[i]   <= '0;
            duty_sh[i] <= '0;
         end
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         div     <= div + 1'b1;
         started <= 1'b1;
         active  <= any_on;
         for (int i = 0; i < CHANNELS; i++) begin
            level[i] <= level_nx[i];
            if (pwm_cnt == MAX)
               duty_sh[i] <= duty[i];
            led_o[i] <= (duty_sh[i] == MAX) | (pwm_cnt < duty_sh[i]);
         end
      end
   end
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed checks of snap-on, decay, priority, saturation and PWM duty.
module tb_led_fade_pwm;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req0 = '0, req1 = '0, req2 = '0, req3 = '0;
   logic [3:0] led0, led1, led2, led3;
   logic       act0, act1, act2, act3;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         cnt;

`ifdef LED_FADE_GAMMA_EN
   localparam int HIGH_128 = 64;
   localparam int HIGH_1   = 0;
`else
   localparam int HIGH_128 = 128;
   localparam int HIGH_1   = 1;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   led_fade_pwm #(.CHANNELS(4), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(64))
      u0 (.clk(clk), .rst_n(rst_n), .led_req(req0), .led_o(led0), .active(act0));
   led_fade_pwm #(.CHANNELS(4), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(155))
      u1 (.clk(clk), .rst_n(rst_n), .led_req(req1), .led_o(led1), .active(act1));
   led_fade_pwm #(.CHANNELS(4), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(200))
      u2 (.clk(clk), .rst_n(rst_n), .led_req(req2), .led_o(led2), .active(act2));
   led_fade_pwm #(.CHANNELS(4), .PWM_BITS(8), .DECAY_DIV(10), .DECAY_STEP(127))
      u3 (.clk(clk), .rst_n(rst_n), .led_req(req3), .led_o(led3), .active(act3));

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_mod(input int m, input int r);
      for (int i = 0; i < m && cyc % m != r; i++) tick_n(1);
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic count_high(output int n);
      n = 0;
      repeat (256) begin
         tick_n(1);
         n += int'(led3[3]);
      end
   endtask

   initial begin
      req0 = '1; req1 = '1; req2 = '1; req3 = '1;
      tick_n(5);
      check("rst_led", int'({led3, led2, led1, led0}), 0);
      check("rst_act", int'({act3, act2, act1, act0}), 0);
      rst_n = 1'b1;
      req0 = '0; req1 = '0; req2 = '0; req3 = '0;
      tick_n(300);
      check("idle_led", int'({led3, led2, led1, led0}), 0);
      check("idle_act", int'({act3, act2, act1, act0}), 0);

      wait_mod(16, 3);
      req0[0] = 1'b1; req1[2] = 1'b1; req2[1] = 1'b1;
      tick_n(1);
      req0 = '0; req1 = '0; req2 = '0;
      check("snap_u0", int'(u0.level[0]), 255);
      check("snap_u1", int'(u1.level[2]), 255);
      check("snap_u2", int'(u2.level[1]), 255);

      wait_mod(16, 1);
      check("dec1_u0", int'(u0.level[0]), 191);
      check("dec1_u1", int'(u1.level[2]), 100);
      check("dec1_u2", int'(u2.level[1]), 55);
      check("dec1_act", int'(act0), 1);

      tick_n(15);
      req1[2] = 1'b1;
      tick_n(1);
      req1 = '0;
      check("dec2_u0", int'(u0.level[0]), 127);
      check("prio_u1", int'(u1.level[2]), 255);
      check("sat_u2", int'(u2.level[1]), 0);

      tick_n(16);
      check("dec3_u0", int'(u0.level[0]), 63);
      check("dec3_u1", int'(u1.level[2]), 100);
      tick_n(16);
      check("dec4_u0", int'(u0.level[0]), 0);
      check("sat_u1", int'(u1.level[2]), 0);
      check("act_lag", int'(act0), 1);
      tick_n(1);
      check("act_off", int'({act2, act1, act0}), 0);
      tick_n(300);
      check("faded_led", int'({led2, led1, led0}), 0);

      wait_mod(1024, 2);
      req3[3] = 1'b1;
      tick_n(1);
      req3 = '0;
      tick_n(520);
      count_high(cnt);
      check("solid_on", cnt, 256);
      check("act3_on", int'(act3), 1);

      wait_mod(1024, 1);
      check("lvl128", int'(u3.level[3]), 128);
      tick_n(520);
      count_high(cnt);
      check("duty128", cnt, HIGH_128);

      wait_mod(1024, 1);
      check("lvl1", int'(u3.level[3]), 1);
      tick_n(520);
      count_high(cnt);
      check("duty1", cnt, HIGH_1);

      wait_mod(1024, 1);
      check("lvl0", int'(u3.level[3]), 0);
      tick_n(520);
      count_high(cnt);
      check("duty0", cnt, 0);
      check("act3_off", int'(act3), 0);

      req0[0] = 1'b1;
      tick_n(1);
      req0 = '0;
      tick_n(2);
      check("mid_act", int'(act0), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_lvl", int'(u0.level[0]), 0);
      check("async_act", int'(act0), 0);
      check("async_led", int'(led0), 0);
      tick_n(2);
      rst_n = 1'b1;
      tick_n(300);
      check("post_act", int'(act0), 0);
      check("post_led", int'(led0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
